// File: rtl/cken_gen.sv
// ---------------------------------------------------------------------------
// cken_gen -- clock-enable generator for the clk28m domain
//
// Replaces derived clocks with single-cycle enables. Everything runs on
// clk28m; downstream logic qualifies its flops with the enables below.
//
// Ports
//   clk28m   in   28.375 MHz system clock (only clock)
//   reset    in   synchronous, active-high reset
//   cck      in   colour clock level (Agnus hpos[0]), one toggle per 7 MHz cycle
//   c1       out  7 MHz phase level, high in phases 0 and 1
//   c3       out  7 MHz phase level 90 degrees later, high in phases 1 and 2
//   clk7_en  out  one-clk28m strobe per 7 MHz cycle (phase 3)
//   eclk     out  one-hot E-clock phase, bit k high while the E counter is k
//   e_slip   out  one-cycle pulse when the E counter held to re-align with cck
//   ch_run   in   per-channel run enable
//   ch_div   in   per-channel divide value, channel i at [i*CW +: CW]
//   ch_en    out  per-channel one-cycle enable pulse
//
// Parameters
//   E_DIV    E-clock period in 7 MHz cycles (even, 4..16)
//   NCH      number of divider channels (1..8)
//   CW       width of each channel divide value / counter
//
// Optional feature (macro CKEN_CCK_LOCK_EN)
//   Defined:   an edge on cck forces the phase counter to 1, so c1/c3/clk7_en
//              follow Agnus exactly; a strobe that the correction skips over
//              is simply not produced.
//   Undefined: the phase counter free-runs from reset and cck is only used
//              for E-clock parity.
// ---------------------------------------------------------------------------
module cken_gen #(
    parameter int E_DIV = 10,
    parameter int NCH   = 2,
    parameter int CW    = 8
) (
    input  logic                clk28m,
    input  logic                reset,
    input  logic                cck,
    output logic                c1,
    output logic                c3,
    output logic                clk7_en,
    output logic [E_DIV-1:0]    eclk,
    output logic                e_slip,
    input  logic [NCH-1:0]      ch_run,
    input  logic [NCH*CW-1:0]   ch_div,
    output logic [NCH-1:0]      ch_en
);

    localparam int             EW     = $clog2(E_DIV);
    localparam logic [EW-1:0]  E_LAST = EW'(E_DIV - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]             ph_q,      ph_d;
    logic                   c1_q,      c1_d;
    logic                   c3_q,      c3_d;
    logic                   clk7_en_q, clk7_en_d;
    logic                   cck_r_q;
    logic [EW-1:0]          e_cnt_q,   e_cnt_d;
    logic [EW-1:0]          e_nxt;
    logic [E_DIV-1:0]       eclk_q,    eclk_d;
    logic                   e_slip_q,  e_slip_d;
    logic [NCH-1:0][CW-1:0] cnt_q,     cnt_d;
    logic [NCH-1:0]         ch_en_q,   ch_en_d;

    // ------------------------------------------------------------------
    // Phase counter and 7 MHz levels. The levels are decoded from the
    // next phase value and registered alongside it, so every output is a
    // plain flop output and cannot glitch.
    // ------------------------------------------------------------------
    always_comb begin
        ph_d = ph_q + 2'd1;
`ifdef CKEN_CCK_LOCK_EN
        // A cck edge marks the start of Agnus' phase 1. Forcing the phase
        // here also drops a strobe that would otherwise have been due.
        if (cck != cck_r_q) begin
            ph_d = 2'd1;
        end
`endif
        c1_d      = (ph_d == 2'd0) || (ph_d == 2'd1);
        c3_d      = (ph_d == 2'd1) || (ph_d == 2'd2);
        clk7_en_d = (ph_d == 2'd3);
    end

    // ------------------------------------------------------------------
    // E-clock counter. It only moves on the 7 MHz strobe, and only when
    // the parity of the value it is about to take matches the inverse of
    // the sampled colour clock. On a mismatch it holds for one strobe,
    // which shifts its parity by one and brings it back in step with cck.
    // ------------------------------------------------------------------
    always_comb begin
        e_nxt    = (e_cnt_q == E_LAST) ? '0 : e_cnt_q + 1'b1;
        e_cnt_d  = e_cnt_q;
        e_slip_d = 1'b0;
        if (clk7_en_q) begin
            if (e_nxt[0] == ~cck_r_q) begin
                e_cnt_d = e_nxt;
            end else begin
                e_slip_d = 1'b1;
            end
        end
    end

    // One-hot E phase, registered together with the counter it decodes.
    always_comb begin
        eclk_d = '0;
        for (int k = 0; k < E_DIV; k++) begin
            eclk_d[k] = (e_cnt_d == EW'(k));
        end
    end

    // ------------------------------------------------------------------
    // Divider channels. A stopped channel keeps reloading its divide
    // value, so starting it gives a full first period and a divide change
    // made while running only lands at the next reload. A pulse that is
    // due in the same cycle as ch_run falls is lost, because the stopped
    // branch wins.
    // ------------------------------------------------------------------
    always_comb begin
        cnt_d   = cnt_q;
        ch_en_d = '0;
        for (int i = 0; i < NCH; i++) begin
            if (!ch_run[i]) begin
                cnt_d[i] = ch_div[i*CW +: CW];
            end else if (clk7_en_q) begin
                if (cnt_q[i] == '0) begin
                    cnt_d[i]   = ch_div[i*CW +: CW];
                    ch_en_d[i] = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] - 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // cck is sampled even during reset, so the first cycle after reset
    // does not see a spurious colour-clock edge.
    // ------------------------------------------------------------------
    always_ff @(posedge clk28m) begin
        cck_r_q <= cck;
    end

    // ------------------------------------------------------------------
    // State registers with synchronous reset. Reset leaves phase 0 with
    // c1 high and the E counter at 0; channel counters clear so no
    // partial pulse can survive a reset.
    // ------------------------------------------------------------------
    always_ff @(posedge clk28m) begin
        if (reset) begin
            ph_q      <= 2'd0;
            c1_q      <= 1'b1;
            c3_q      <= 1'b0;
            clk7_en_q <= 1'b0;
            e_cnt_q   <= '0;
            eclk_q    <= E_DIV'(1);
            e_slip_q  <= 1'b0;
            cnt_q     <= '0;
            ch_en_q   <= '0;
        end else begin
            ph_q      <= ph_d;
            c1_q      <= c1_d;
            c3_q      <= c3_d;
            clk7_en_q <= clk7_en_d;
            e_cnt_q   <= e_cnt_d;
            eclk_q    <= eclk_d;
            e_slip_q  <= e_slip_d;
            cnt_q     <= cnt_d;
            ch_en_q   <= ch_en_d;
        end
    end

    assign c1      = c1_q;
    assign c3      = c3_q;
    assign clk7_en = clk7_en_q;
    assign eclk    = eclk_q;
    assign e_slip  = e_slip_q;
    assign ch_en   = ch_en_q;

endmodule

// File: tb/tb_cken_gen.sv
// ---------------------------------------------------------------------------
// tb_cken_gen -- self-checking bench for cken_gen
//
// A behavioural model (plain integer phase/counter arithmetic) is stepped on
// every clk28m edge and all outputs are compared against it half a cycle
// later. Directed sections check reset values, the 7 MHz pattern, the
// E-clock wrap and slip, channel periods, run-fall suppression and reset
// mid-count; a randomized section follows.
// ---------------------------------------------------------------------------
module tb_cken_gen;

    localparam int E_DIV = 10;
    localparam int NCH   = 2;
    localparam int CW    = 8;

    logic                clk28m = 1'b0;
    logic                reset;
    logic                cck;
    logic                c1;
    logic                c3;
    logic                clk7_en;
    logic [E_DIV-1:0]    eclk;
    logic                e_slip;
    logic [NCH-1:0]      ch_run;
    logic [NCH*CW-1:0]   ch_div;
    logic [NCH-1:0]      ch_en;

    cken_gen #(.E_DIV(E_DIV), .NCH(NCH), .CW(CW)) dut (
        .clk28m  (clk28m),
        .reset   (reset),
        .cck     (cck),
        .c1      (c1),
        .c3      (c3),
        .clk7_en (clk7_en),
        .eclk    (eclk),
        .e_slip  (e_slip),
        .ch_run  (ch_run),
        .ch_div  (ch_div),
        .ch_en   (ch_en)
    );

    always #5 clk28m = ~clk28m;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int m_ph;
    int m_e;
    int m_slip;
    bit m_cck_r;
    int m_cnt [NCH];
    int m_en  [NCH];
    int cyc;

    // Stimulus control
    bit inv_req;
    int inv_left;
    bit chaos;

    // Directed-test scratch
    int slips;
    int found;
    bit prev0;
    int n44;
    int nbad;
    int rises [$];
    int pulses [$];
    logic [3:0] c1_pat  = 4'b0011;
    logic [3:0] c3_pat  = 4'b0110;
    logic [3:0] c7_pat  = 4'b1000;

    // Single comparison point
    task automatic compare(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Model: one clk28m edge, using the inputs held across that edge
    task automatic modelStep();
        int nph;
        int nxt;
        int dv;
        if (reset) begin
            m_ph   = 0;
            m_e    = 0;
            m_slip = 0;
            for (int i = 0; i < NCH; i++) begin
                m_cnt[i] = 0;
                m_en[i]  = 0;
            end
        end else begin
            nph = (m_ph + 1) % 4;
`ifdef CKEN_CCK_LOCK_EN
            if (cck != m_cck_r) nph = 1;
`endif
            m_slip = 0;
            if (m_ph == 3) begin
                nxt = (m_e + 1) % E_DIV;
                if ((nxt % 2) != int'(m_cck_r)) m_e = nxt;
                else m_slip = 1;
            end
            for (int i = 0; i < NCH; i++) begin
                dv = int'(ch_div[i*CW +: CW]);
                m_en[i] = 0;
                if (!ch_run[i]) begin
                    m_cnt[i] = dv;
                end else if (m_ph == 3) begin
                    if (m_cnt[i] == 0) begin
                        m_cnt[i] = dv;
                        m_en[i]  = 1;
                    end else begin
                        m_cnt[i] = m_cnt[i] - 1;
                    end
                end
            end
            m_ph = nph;
        end
        m_cck_r = cck;
        cyc++;
    endtask

    // Drive cck for the current cycle: in step with the E counter, inverted
    // for one whole 7 MHz cycle on request, or randomly in chaos mode.
    task automatic applyStimulus();
        if (chaos) begin
            if ($urandom_range(0, 5) == 0) cck = ~cck;
        end else begin
            if (inv_req && m_ph == 0) begin
                inv_left = 4;
                inv_req  = 1'b0;
            end
            cck = 1'(m_e % 2) ^ (inv_left > 0);
            if (inv_left > 0) inv_left--;
        end
    endtask

    task automatic checkOutput();
        logic [NCH-1:0] exp_en;
        for (int i = 0; i < NCH; i++) exp_en[i] = (m_en[i] != 0);
        compare("c1",      32'(c1),      32'(m_ph < 2));
        compare("c3",      32'(c3),      32'(m_ph == 1 || m_ph == 2));
        compare("clk7_en", 32'(clk7_en), 32'(m_ph == 3));
        compare("eclk",    32'(eclk),    32'(1) << m_e);
        compare("e_slip",  32'(e_slip),  32'(m_slip));
        compare("ch_en",   32'(ch_en),   32'(exp_en));
    endtask

    task automatic cycle();
        applyStimulus();
        @(posedge clk28m);
        modelStep();
        @(negedge clk28m);
        checkOutput();
    endtask

    task automatic checkResetValues(input string tag);
        compare({tag, "_c1"},    32'(c1),      32'(1));
        compare({tag, "_c3"},    32'(c3),      32'(0));
        compare({tag, "_clk7"},  32'(clk7_en), 32'(0));
        compare({tag, "_eclk"},  32'(eclk),    32'(1));
        compare({tag, "_slip"},  32'(e_slip),  32'(0));
        compare({tag, "_ch_en"}, 32'(ch_en),   32'(0));
    endtask

    initial begin
        reset    = 1'b1;
        cck      = 1'b0;
        ch_run   = '0;
        ch_div   = '0;
        inv_req  = 1'b0;
        inv_left = 0;
        chaos    = 1'b0;
        m_ph = 0; m_e = 0; m_slip = 0; m_cck_r = 1'b0; cyc = 0;
        for (int i = 0; i < NCH; i++) begin
            m_cnt[i] = 0;
            m_en[i]  = 0;
        end

        // Reset state
        cycle();
        cycle();
        checkResetValues("reset");

        // 7 MHz pattern and E-clock walk with cck in step
        reset = 1'b0;
        slips = 0;
        for (int k = 1; k <= 40; k++) begin
            cycle();
            if (e_slip) slips++;
            if (k < 16) begin
                compare("c1_pat",   32'(c1),      32'(c1_pat[k % 4]));
                compare("c3_pat",   32'(c3),      32'(c3_pat[k % 4]));
                compare("clk7_pat", 32'(clk7_en), 32'(c7_pat[k % 4]));
            end
            if (k == 36) compare("eclk_bit9", 32'(eclk), 32'h200);
            if (k == 40) compare("eclk_wrap", 32'(eclk), 32'h001);
        end
        compare("no_slip_in_step", 32'(slips), 32'(0));

        // One inverted 7 MHz cycle of cck: one slip, one stretched period
        prev0 = eclk[0];
        found = 0;
        for (int n = 0; n < 60 && found == 0; n++) begin
            cycle();
            if (eclk[0] && !prev0) found = 1;
            prev0 = eclk[0];
        end
        compare("eclk_rise_seen", 32'(found), 32'(1));
        inv_req = 1'b1;
        slips = 0;
        rises.delete();
        rises.push_back(cyc);
        for (int n = 0; n < 100; n++) begin
            cycle();
            if (e_slip) slips++;
            if (eclk[0] && !prev0) rises.push_back(cyc);
            prev0 = eclk[0];
        end
        n44 = 0; nbad = 0;
        for (int j = 1; j < rises.size(); j++) begin
            if (rises[j] - rises[j-1] == 44) n44++;
            else if (rises[j] - rises[j-1] != 40) nbad++;
        end
        compare("slip_count",     32'(slips), 32'(1));
        compare("period44_count", 32'(n44),   32'(1));
        compare("period_other",   32'(nbad),  32'(0));
        compare("rise_count_ok",  32'(rises.size() >= 3), 32'(1));

        // Channel 0 divide-by-4 strobes: pulse every 16 clk28m cycles
        ch_div[0 +: CW] = 8'd3;
        ch_run[0] = 1'b1;
        pulses.delete();
        for (int n = 0; n < 70; n++) begin
            cycle();
            if (ch_en[0]) pulses.push_back(cyc);
        end
        nbad = 0;
        for (int j = 1; j < pulses.size(); j++)
            if (pulses[j] - pulses[j-1] != 16) nbad++;
        compare("ch0_period16",   32'(nbad), 32'(0));
        compare("ch0_pulse_count", 32'(pulses.size() >= 4), 32'(1));

        // Divide change mid-period lands at the next reload
        found = 0;
        for (int n = 0; n < 20 && found == 0; n++) begin
            cycle();
            if (ch_en[0]) found = 1;
        end
        compare("ch0_pulse_seen", 32'(found), 32'(1));
        pulses.delete();
        pulses.push_back(cyc);
        cycle();
        cycle();
        ch_div[0 +: CW] = 8'd0;
        for (int n = 0; n < 40; n++) begin
            cycle();
            if (ch_en[0]) pulses.push_back(cyc);
        end
        nbad = 0;
        for (int j = 2; j < pulses.size(); j++)
            if (pulses[j] - pulses[j-1] != 4) nbad++;
        compare("ch0_old_period", 32'(pulses.size() >= 2 ? pulses[1] - pulses[0] : 0), 32'(16));
        compare("ch0_new_period", 32'(nbad), 32'(0));
        compare("ch0_new_count",  32'(pulses.size() >= 6), 32'(1));

        // ch_run falling on the strobe of a due pulse suppresses it
        found = 0;
        for (int n = 0; n < 8 && found == 0; n++) begin
            cycle();
            if (clk7_en) found = 1;
        end
        compare("strobe_seen", 32'(found), 32'(1));
        ch_run[0] = 1'b0;
        cycle();
        compare("run_fall_suppress", 32'(ch_en[0]), 32'(0));

        // Reset while channel count is at 1
        ch_div[0 +: CW] = 8'd3;
        ch_run[0] = 1'b1;
        found = 0;
        for (int n = 0; n < 40 && found == 0; n++) begin
            cycle();
            if (m_cnt[0] == 1) found = 1;
        end
        compare("count1_reached", 32'(found), 32'(1));
        reset = 1'b1;
        cycle();
        checkResetValues("midreset");
        reset = 1'b0;
        for (int n = 0; n < 8; n++) begin
            cycle();
            if (n < 3) compare("no_pulse_after_reset", 32'(ch_en[0]), 32'(0));
        end

        // Randomized operation against the model
        for (int n = 0; n < 1500; n++) begin
            if (reset) reset = 1'b0;
            else if ($urandom_range(0, 299) == 0) reset = 1'b1;
            if ($urandom_range(0, 49) == 0) ch_run = NCH'($urandom);
            if ($urandom_range(0, 29) == 0)
                for (int i = 0; i < NCH; i++) ch_div[i*CW +: CW] = CW'($urandom_range(0, 5));
            if ($urandom_range(0, 199) == 0) inv_req = 1'b1;
            cycle();
        end
        reset = 1'b0;
        chaos = 1'b1;
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 49) == 0) ch_run = NCH'($urandom);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
